// File: rtl/router_data_register_pkg.sv
// router_data_register_pkg: shared width, address codes and FSM state encodings
package router_data_register_pkg;
    localparam int DATA_WIDTH = 8;
    typedef enum logic [1:0] {
        ADDR_0       = 2'b00,
        ADDR_1       = 2'b01,
        ADDR_2       = 2'b10,
        ADDR_INVALID = 2'b11
    } addr_t;
    typedef enum logic [3:0] {
        DECODE_ADDRESS  = 4'b0001,
        LOAD_FIRST_DATA = 4'b0010,
        LOAD_DATA       = 4'b0100,
        LOAD_AFTER_FULL = 4'b1000
    } state_t;
    function automatic logic addr_valid(input logic [1:0] a);
        return a != ADDR_INVALID;
    endfunction
endpackage

// File: rtl/router_parity_checker.sv
// router_parity_checker: running XOR parity, trailing parity capture and error flag
module router_parity_checker
    import router_data_register_pkg::*;
#(
    parameter int DATA_WIDTH = router_data_register_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  addr_det,
    input  logic                  first_data,
    input  logic                  load_data,
    input  logic                  full_state,
    input  logic                  packet_valid,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] header,
    input  logic                  parity_done,
    output logic                  error
);
    logic [DATA_WIDTH-1:0] int_parity, pkt_parity;
    logic                  done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_parity <= '0;
            pkt_parity <= '0;
            done_d     <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (addr_det)
                int_parity <= '0;
            else if (first_data)
                int_parity <= int_parity ^ header;
            else if (load_data && packet_valid && !full_state)
                int_parity <= int_parity ^ data;
            if (load_data && !packet_valid)
                pkt_parity <= data;
            done_d <= parity_done;
            // compare once, on the rising edge of parity_done; hold until next header
            if (parity_done && !done_d)
                error <= int_parity != pkt_parity;
            else if (addr_det && packet_valid)
                error <= 1'b0;
        end
    end
endmodule

// File: rtl/router_data_register.sv
// router_data_register: header/stall staging and output byte mux for the router datapath
module router_data_register
    import router_data_register_pkg::*;
#(
    parameter int DATA_WIDTH = router_data_register_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Sig_Packet_Valid,
    input  logic [DATA_WIDTH-1:0] i_Input_Data,
    input  logic                  i_Sig_Fifo_Full,
    input  logic                  i_Sig_Address_Detected,
    input  logic                  i_Load_First_Data_State,
    input  logic                  i_Load_Data_State,
    input  logic                  i_Load_After_State,
    input  logic                  i_Full_State,
    input  logic                  i_Reset_Low_Packet_Valid_Reg,
    output logic [DATA_WIDTH-1:0] o_Output_Data,
    output logic                  o_Sig_Parity_Done,
    output logic                  o_Sig_Low_Packet_Valid,
    output logic                  o_Sig_Error
);
    logic [DATA_WIDTH-1:0] header, full_reg;
    logic                  done_set;

    assign done_set = (i_Load_Data_State && !i_Sig_Fifo_Full && !i_Sig_Packet_Valid)
                   || (i_Load_After_State && o_Sig_Low_Packet_Valid && !o_Sig_Parity_Done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            header                 <= '0;
            full_reg               <= '0;
            o_Output_Data          <= '0;
            o_Sig_Low_Packet_Valid <= 1'b0;
            o_Sig_Parity_Done      <= 1'b0;
        end else begin
            if (i_Sig_Address_Detected && i_Sig_Packet_Valid && addr_valid(i_Input_Data[1:0]))
                header <= i_Input_Data;
            if (i_Load_First_Data_State)
                o_Output_Data <= header;
            else if (i_Load_Data_State && !i_Sig_Fifo_Full)
                o_Output_Data <= i_Input_Data;
            else if (i_Load_Data_State)
                full_reg <= i_Input_Data;
            else if (i_Load_After_State)
                o_Output_Data <= full_reg;
            if (i_Load_Data_State && !i_Sig_Packet_Valid)
                o_Sig_Low_Packet_Valid <= 1'b1;
            else if (i_Reset_Low_Packet_Valid_Reg)
                o_Sig_Low_Packet_Valid <= 1'b0;
            if (done_set)
                o_Sig_Parity_Done <= 1'b1;
            else if (i_Sig_Address_Detected)
                o_Sig_Parity_Done <= 1'b0;
        end
    end

    router_parity_checker #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .clk         (clk),
        .reset       (reset),
        .addr_det    (i_Sig_Address_Detected),
        .first_data  (i_Load_First_Data_State),
        .load_data   (i_Load_Data_State),
        .full_state  (i_Full_State),
        .packet_valid(i_Sig_Packet_Valid),
        .data        (i_Input_Data),
        .header      (header),
        .parity_done (o_Sig_Parity_Done),
        .error       (o_Sig_Error)
    );
endmodule

// File: tb/tb_router_data_register.sv
// tb_router_data_register: directed FSM-strobe sequences with hand-computed expectations
module tb_router_data_register;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pv = 1'b0, fifo_full = 1'b0;
    logic [7:0] din = '0;
    logic       addr_det = 1'b0, first = 1'b0, ld = 1'b0, after = 1'b0, full_st = 1'b0, rst_low = 1'b0;
    logic [7:0] dout;
    logic       done, low_pv, err;
    int         tests = 0, fails = 0;

    localparam logic [5:0] S_ADDR = 6'b000001, S_FIRST = 6'b000010, S_LD = 6'b000100,
                           S_AFTER = 6'b001000, S_FULL = 6'b010000, S_CHK = 6'b100000,
                           S_NONE = 6'b000000;

    router_data_register dut (
        .clk                         (clk),
        .reset                       (reset),
        .i_Sig_Packet_Valid          (pv),
        .i_Input_Data                (din),
        .i_Sig_Fifo_Full             (fifo_full),
        .i_Sig_Address_Detected      (addr_det),
        .i_Load_First_Data_State     (first),
        .i_Load_Data_State           (ld),
        .i_Load_After_State          (after),
        .i_Full_State                (full_st),
        .i_Reset_Low_Packet_Valid_Reg(rst_low),
        .o_Output_Data               (dout),
        .o_Sig_Parity_Done           (done),
        .o_Sig_Low_Packet_Valid      (low_pv),
        .o_Sig_Error                 (err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [5:0] s, input logic v, input logic [7:0] d, input logic f);
        {rst_low, full_st, after, ld, first, addr_det} = s;
        pv = v;
        din = d;
        fifo_full = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic flags(input string tag, input logic d, input logic l, input logic e);
        check({tag, "_done"}, {7'd0, done}, {7'd0, d});
        check({tag, "_low"}, {7'd0, low_pv}, {7'd0, l});
        check({tag, "_err"}, {7'd0, err}, {7'd0, e});
    endtask

    initial begin
        #12;
        check("rst_out", dout, 8'h00);
        flags("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        // clean packet: 0C, 11, 22, 33, parity 0C
        step(S_ADDR, 1, 8'h0C, 0);
        step(S_FIRST, 1, 8'h11, 0);
        check("clean_hdr", dout, 8'h0C);
        step(S_LD, 1, 8'h11, 0);
        check("clean_b1", dout, 8'h11);
        step(S_LD, 1, 8'h22, 0);
        check("clean_b2", dout, 8'h22);
        step(S_LD, 1, 8'h33, 0);
        check("clean_b3", dout, 8'h33);
        step(S_LD, 0, 8'h0C, 0);
        check("clean_par", dout, 8'h0C);
        flags("clean_pd", 1'b1, 1'b1, 1'b0);
        step(S_CHK, 0, 8'h00, 0);
        flags("clean_chk", 1'b1, 1'b0, 1'b0);
        // same packet, bad parity byte 00
        step(S_ADDR, 1, 8'h0C, 0);
        check("bad_done_clr", {7'd0, done}, 8'h00);
        step(S_FIRST, 1, 8'h11, 0);
        step(S_LD, 1, 8'h11, 0);
        step(S_LD, 1, 8'h22, 0);
        step(S_LD, 1, 8'h33, 0);
        step(S_LD, 0, 8'h00, 0);
        flags("bad_pd", 1'b1, 1'b1, 1'b0);
        step(S_CHK, 0, 8'h00, 0);
        flags("bad_chk", 1'b1, 1'b0, 1'b1);
        step(S_NONE, 0, 8'h00, 0);
        check("bad_hold", {7'd0, err}, 8'h01);
        // next header clears error; FIFO full while 22 is presented
        step(S_ADDR, 1, 8'h0C, 0);
        flags("stall_hdr", 1'b0, 1'b0, 1'b0);
        step(S_FIRST, 1, 8'h11, 0);
        step(S_LD, 1, 8'h11, 0);
        step(S_LD, 1, 8'h22, 1);
        check("stall_hold", dout, 8'h11);
        step(S_FULL, 1, 8'h33, 1);
        check("stall_full", dout, 8'h11);
        step(S_AFTER, 1, 8'h33, 0);
        check("stall_after", dout, 8'h22);
        check("stall_nodone", {7'd0, done}, 8'h00);
        step(S_LD, 1, 8'h33, 0);
        check("stall_b3", dout, 8'h33);
        step(S_LD, 0, 8'h0C, 0);
        check("stall_par", dout, 8'h0C);
        step(S_CHK, 0, 8'h00, 0);
        flags("stall_chk", 1'b1, 1'b0, 1'b0);
        // header 09 (len 2, addr 1), AA, BB, parity 09^AA^BB=18, FIFO full on parity byte
        step(S_ADDR, 1, 8'h09, 0);
        step(S_FIRST, 1, 8'hAA, 0);
        check("pfull_hdr", dout, 8'h09);
        step(S_LD, 1, 8'hAA, 0);
        step(S_LD, 1, 8'hBB, 0);
        check("pfull_b2", dout, 8'hBB);
        step(S_LD, 0, 8'h18, 1);
        check("pfull_hold", dout, 8'hBB);
        flags("pfull_stall", 1'b0, 1'b1, 1'b0);
        step(S_FULL, 0, 8'h18, 1);
        step(S_AFTER, 0, 8'h18, 0);
        check("pfull_after", dout, 8'h18);
        flags("pfull_pd", 1'b1, 1'b1, 1'b0);
        step(S_CHK, 0, 8'h00, 0);
        flags("pfull_chk", 1'b1, 1'b0, 1'b0);
        // invalid address 07: header stays 09, output unchanged
        step(S_ADDR, 1, 8'h07, 0);
        check("inv_out", dout, 8'h18);
        step(S_FIRST, 1, 8'h55, 0);
        check("inv_hdr", dout, 8'h09);
        // async reset mid-packet
        step(S_LD, 1, 8'h55, 0);
        check("mid_out", dout, 8'h55);
        reset = 1'b0;
        #1;
        check("arst_out", dout, 8'h00);
        flags("arst", 1'b0, 1'b0, 1'b0);
        step(S_LD, 0, 8'h77, 0);
        check("arst_hold", dout, 8'h00);
        reset = 1'b1;
        // fresh packet after reset: no leftover parity
        step(S_ADDR, 1, 8'h04, 0);
        step(S_FIRST, 1, 8'h3C, 0);
        check("post_hdr", dout, 8'h04);
        step(S_LD, 1, 8'h3C, 0);
        step(S_LD, 0, 8'h38, 0);
        check("post_par", dout, 8'h38);
        step(S_CHK, 0, 8'h00, 0);
        flags("post_chk", 1'b1, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
